// File: rtl/unary_op_control.sv
// Control sequencer for the phase-1 datapath: fetches one instruction, then
// executes NOT / NEG Ra,Rb or flags an illegal opcode and aborts.
module unary_op_control #(
  parameter logic [4:0] OP_NOT = 5'b10010,
  parameter logic [4:0] OP_NEG = 5'b10001
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        pc_out,
  output logic        mar_in,
  output logic        pc_increment,
  output logic        pc_enable,
  output logic        mdr_read,
  output logic        mdr_enable,
  output logic        mdr_out,
  output logic        ir_enable,
  output logic        y_enable,
  output logic        zlo_enable,
  output logic        zlo_out,
  output logic [4:0]  op_code,
  output logic [15:0] reg_enable,
  output logic [15:0] reg_out,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_T0      = 4'd1,
    S_T1      = 4'd2,
    S_T2      = 4'd3,
    S_T3      = 4'd4,
    S_T4      = 4'd5,
    S_T5      = 4'd6,
    S_T6      = 4'd7,
    S_DONE    = 4'd8,
    S_ILLEGAL = 4'd9
  } state_t;

  state_t state_q, state_d;

  logic [4:0] opc_q;
  logic [3:0] ra_q;
  logic [3:0] rb_q;

  logic        pcOut_q, marIn_q, pcInc_q;
  logic        mdrRead_q, mdrEn_q, mdrOut_q, irEn_q;
  logic        zloEn_q, zloOut_q;
  logic [4:0]  opCode_q;
  logic [15:0] regEn_q, regOut_q;
  logic        busy_q, done_q, illegal_q;

  logic [4:0] irOpc;
  logic [3:0] irRa;
  logic [3:0] irRb;
  logic       irLegal;
  logic [4:0] opcSel;
  logic [3:0] rbSel;

  assign irOpc   = ir[31:27];
  assign irRa    = ir[26:23];
  assign irRb    = ir[22:19];
  assign irLegal = (irOpc == OP_NOT) || (irOpc == OP_NEG);

  // Leaving T3 the latches are only being loaded, so T4 outputs come straight from ir.
  assign opcSel = (state_q == S_T3) ? irOpc : opc_q;
  assign rbSel  = (state_q == S_T3) ? irRb  : rb_q;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = start ? S_T0 : S_IDLE;
      S_T0:      state_d = S_T1;
      S_T1:      state_d = S_T2;
      S_T2:      state_d = S_T3;
      S_T3:      state_d = irLegal ? S_T4 : S_ILLEGAL;
      S_T4:      state_d = S_T5;
      S_T5:      state_d = S_T6;
      S_T6:      state_d = S_DONE;
      S_DONE:    state_d = start ? S_T0 : S_IDLE;
      S_ILLEGAL: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered by decoding the state being entered, so they line up with state_q.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      opc_q     <= 5'd0;
      ra_q      <= 4'd0;
      rb_q      <= 4'd0;
      pcOut_q   <= 1'b0;
      marIn_q   <= 1'b0;
      pcInc_q   <= 1'b0;
      mdrRead_q <= 1'b0;
      mdrEn_q   <= 1'b0;
      mdrOut_q  <= 1'b0;
      irEn_q    <= 1'b0;
      zloEn_q   <= 1'b0;
      zloOut_q  <= 1'b0;
      opCode_q  <= 5'd0;
      regEn_q   <= 16'd0;
      regOut_q  <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcOut_q   <= 1'b0;
      marIn_q   <= 1'b0;
      pcInc_q   <= 1'b0;
      mdrRead_q <= 1'b0;
      mdrEn_q   <= 1'b0;
      mdrOut_q  <= 1'b0;
      irEn_q    <= 1'b0;
      zloEn_q   <= 1'b0;
      zloOut_q  <= 1'b0;
      opCode_q  <= 5'd0;
      regEn_q   <= 16'd0;
      regOut_q  <= 16'd0;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= 1'b0;
      illegal_q <= 1'b0;

      if (state_q == S_T3) begin
        opc_q <= irOpc;
        ra_q  <= irRa;
        rb_q  <= irRb;
      end

      case (state_d)
        S_T0: begin
          pcOut_q <= 1'b1;
          marIn_q <= 1'b1;
          pcInc_q <= 1'b1;
        end
        S_T1: begin
          mdrRead_q <= 1'b1;
          mdrEn_q   <= 1'b1;
        end
        S_T2: begin
          mdrOut_q <= 1'b1;
          irEn_q   <= 1'b1;
        end
        S_T4: begin
          regOut_q <= 16'h0001 << rbSel;
          opCode_q <= opcSel;
        end
        S_T5: begin
          regOut_q <= 16'h0001 << rbSel;
          opCode_q <= opcSel;
          zloEn_q  <= 1'b1;
        end
        S_T6: begin
          zloOut_q <= 1'b1;
          regEn_q  <= 16'h0001 << ra_q;
        end
        S_DONE:    done_q    <= 1'b1;
        S_ILLEGAL: illegal_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign pc_out       = pcOut_q;
  assign mar_in       = marIn_q;
  assign pc_increment = pcInc_q;
  assign pc_enable    = 1'b0;
  assign mdr_read     = mdrRead_q;
  assign mdr_enable   = mdrEn_q;
  assign mdr_out      = mdrOut_q;
  assign ir_enable    = irEn_q;
  assign y_enable     = 1'b0;
  assign zlo_enable   = zloEn_q;
  assign zlo_out      = zloOut_q;
  assign op_code      = opCode_q;
  assign reg_enable   = regEn_q;
  assign reg_out      = regOut_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign illegal      = illegal_q;

endmodule
